// File: rtl/eth_pkg.sv
// Ethernet/ARP constants shared by the GMII RX and TX stages, plus the byte-wide reflected CRC-32 step.
// Latency: n/a (constants and a combinational function only).
// Backpressure: n/a.
package eth_pkg;

    localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
    localparam logic [15:0] ARP_OPER_REQ   = 16'h0001;
    localparam logic [15:0] ARP_OPER_REPLY = 16'h0002;
    localparam logic [7:0]  ARP_HLEN_ETH   = 8'd6;
    localparam logic [7:0]  ARP_PLEN_IPV4  = 8'd4;

    localparam logic [7:0]  PREAMBLE       = 8'h55;
    localparam logic [7:0]  SFD            = 8'hD5;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    // Register value left after running data plus its own FCS through the CRC.
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

    localparam logic [10:0] MIN_FRAME = 11'd64;
    localparam logic [10:0] MAX_FRAME = 11'd1518;

    // Byte offsets counted from the first byte after SFD.
    localparam logic [10:0] OFF_DST   = 11'd0;
    localparam logic [10:0] OFF_ETYPE = 11'd12;
    localparam logic [10:0] OFF_HTYPE = 11'd14;
    localparam logic [10:0] OFF_PTYPE = 11'd16;
    localparam logic [10:0] OFF_HLEN  = 11'd18;
    localparam logic [10:0] OFF_PLEN  = 11'd19;
    localparam logic [10:0] OFF_OPER  = 11'd20;
    localparam logic [10:0] OFF_SHA   = 11'd22;
    localparam logic [10:0] OFF_SPA   = 11'd28;
    localparam logic [10:0] OFF_THA   = 11'd32;
    localparam logic [10:0] OFF_TPA   = 11'd38;

    // Header fields captured while the frame streams in.
    typedef struct packed {
        logic [47:0] dst;
        logic [15:0] etype;
        logic [15:0] htype;
        logic [15:0] ptype;
        logic [7:0]  hlen;
        logic [7:0]  plen;
        logic [15:0] oper;
        logic [47:0] sha;
        logic [31:0] spa;
        logic [31:0] tpa;
    } arp_hdr_t;

    // One byte of reflected CRC-32, LSB of the byte first.
    function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

    // True when idx lies in [lo, lo+n).
    function automatic logic in_field(input logic [10:0] idx, input logic [10:0] lo, input logic [10:0] n);
        return (idx >= lo) && (idx < (lo + n));
    endfunction

endpackage

// File: rtl/arp_reply_rx_if.sv
// GMII receive byte stream in, ARP reply result and frame statistics out.
// Latency: n/a (signal bundle only).
// Backpressure: none; the source delivers one byte per clock while rx_dv is high.
interface arp_reply_rx_if;
    logic        rx_dv;
    logic [7:0]  rx_data;
    logic        reply_valid;
    logic [47:0] reply_mac;
    logic [31:0] reply_ip;
    logic [15:0] good_cnt;
    logic [15:0] crc_err_cnt;

    // master: drives the GMII byte stream and observes results
    modport master (output rx_dv, rx_data,
                    input  reply_valid, reply_mac, reply_ip, good_cnt, crc_err_cnt);
    // slave: the receiver itself
    modport slave  (input  rx_dv, rx_data,
                    output reply_valid, reply_mac, reply_ip, good_cnt, crc_err_cnt);
endinterface

// File: rtl/crc32_d8.sv
// Byte-wide reflected CRC-32 register; shared by the GMII RX checker and TX generator.
// Latency: state reflects a byte on the edge after it is presented with i_en.
// Backpressure: none; i_init takes priority over i_en.
// Ports: clock, reset_n (sync, active-low), i_init (reload 0xFFFFFFFF), i_en (absorb i_data), o_crc.
module crc32_d8
    import eth_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        i_init,
    input  logic        i_en,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);
    logic [31:0] r_crc;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_crc <= CRC32_INIT;
        end else if (i_init) begin
            r_crc <= CRC32_INIT;
        end else if (i_en) begin
            r_crc <= crc32_step(r_crc, i_data);
        end
    end

    assign o_crc = r_crc;
endmodule

// File: rtl/arp_reply_rx.sv
// GMII RX: strips preamble/SFD, checks FCS, counts frames, and reports ARP replies from PEER_IP to LOCAL_IP.
// Latency: results update on the 2nd edge after rx_dv falls (one CHECK cycle); reply_valid is a 1-cycle pulse.
// Backpressure: none; a byte is consumed every clock while rx_dv is high.
// Ports: clock, reset_n (sync, active-low), bus (slave): rx_dv/rx_data in; reply_valid, reply_mac,
//        reply_ip, good_cnt, crc_err_cnt out.
module arp_reply_rx
    import eth_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC = 48'h00301ba0a48e,
    parameter logic [31:0] LOCAL_IP  = 32'h0a00150a,
    parameter logic [31:0] PEER_IP   = 32'h0a001563
)(
    input  logic           clock,
    input  logic           reset_n,
    arp_reply_rx_if.slave  bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRE   = 3'd1;
    localparam logic [2:0] S_BODY  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DROP  = 3'd4;

    logic [2:0]  r_state;
    logic [2:0]  r_pre_cnt;   // number of 0x55 bytes seen so far
    logic [10:0] r_idx;       // bytes received after SFD, FCS included
    arp_hdr_t    r_hdr;
    logic        r_reply_valid;
    logic [47:0] r_reply_mac;
    logic [31:0] r_reply_ip;
    logic [15:0] r_good_cnt;
    logic [15:0] r_crc_err_cnt;

    logic        w_byte_take;
    logic [31:0] w_crc;
    logic        w_arp_match;

    // A byte enters the CRC and field capture only when it is part of a legal-length body.
    assign w_byte_take = (r_state == S_BODY) && bus.rx_dv && (r_idx != MAX_FRAME);

    crc32_d8 u_crc (
        .clock   (clock),
        .reset_n (reset_n),
        .i_init  (r_state != S_BODY),
        .i_en    (w_byte_take),
        .i_data  (bus.rx_data),
        .o_crc   (w_crc)
    );

    assign w_arp_match = ((r_hdr.dst == LOCAL_MAC) || (r_hdr.dst == 48'hFFFF_FFFF_FFFF)) &&
                         (r_hdr.etype == ETHERTYPE_ARP)  && (r_hdr.htype == ARP_HTYPE_ETH) &&
                         (r_hdr.ptype == ETHERTYPE_IPV4) && (r_hdr.hlen  == ARP_HLEN_ETH)  &&
                         (r_hdr.plen  == ARP_PLEN_IPV4)  && (r_hdr.oper  == ARP_OPER_REPLY) &&
                         (r_hdr.spa   == PEER_IP)        && (r_hdr.tpa   == LOCAL_IP);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_pre_cnt     <= 3'd0;
            r_idx         <= 11'd0;
            r_hdr         <= '0;
            r_reply_valid <= 1'b0;
            r_reply_mac   <= 48'd0;
            r_reply_ip    <= 32'd0;
            r_good_cnt    <= 16'd0;
            r_crc_err_cnt <= 16'd0;
        end else begin
            r_reply_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.rx_dv) begin
                        if (bus.rx_data == PREAMBLE) begin
                            r_state   <= S_PRE;
                            r_pre_cnt <= 3'd1;
                        end else if (bus.rx_data == SFD) begin
                            r_state <= S_BODY;
                            r_idx   <= 11'd0;
                        end else begin
                            r_state <= S_DROP;
                        end
                    end
                end
                S_PRE: begin
                    if (!bus.rx_dv) begin
                        r_state <= S_IDLE;
                    end else if (bus.rx_data == PREAMBLE) begin
                        if (r_pre_cnt == 3'd7) begin
                            r_state <= S_DROP;
                        end else begin
                            r_pre_cnt <= r_pre_cnt + 3'd1;
                        end
                    end else if (bus.rx_data == SFD) begin
                        r_state <= S_BODY;
                        r_idx   <= 11'd0;
                    end else begin
                        r_state <= S_DROP;
                    end
                end
                S_BODY: begin
                    if (!bus.rx_dv) begin
                        r_state <= S_CHECK;
                    end else if (r_idx == MAX_FRAME) begin
                        r_state <= S_DROP;
                    end else begin
                        r_idx <= r_idx + 11'd1;
                        // Big-endian fields: shift each byte in at the LSB end.
                        if (in_field(r_idx, OFF_DST, 11'd6))   r_hdr.dst   <= {r_hdr.dst[39:0], bus.rx_data};
                        if (in_field(r_idx, OFF_ETYPE, 11'd2)) r_hdr.etype <= {r_hdr.etype[7:0], bus.rx_data};
                        if (in_field(r_idx, OFF_HTYPE, 11'd2)) r_hdr.htype <= {r_hdr.htype[7:0], bus.rx_data};
                        if (in_field(r_idx, OFF_PTYPE, 11'd2)) r_hdr.ptype <= {r_hdr.ptype[7:0], bus.rx_data};
                        if (r_idx == OFF_HLEN)                 r_hdr.hlen  <= bus.rx_data;
                        if (r_idx == OFF_PLEN)                 r_hdr.plen  <= bus.rx_data;
                        if (in_field(r_idx, OFF_OPER, 11'd2))  r_hdr.oper  <= {r_hdr.oper[7:0], bus.rx_data};
                        if (in_field(r_idx, OFF_SHA, 11'd6))   r_hdr.sha   <= {r_hdr.sha[39:0], bus.rx_data};
                        if (in_field(r_idx, OFF_SPA, 11'd4))   r_hdr.spa   <= {r_hdr.spa[23:0], bus.rx_data};
                        if (in_field(r_idx, OFF_TPA, 11'd4))   r_hdr.tpa   <= {r_hdr.tpa[23:0], bus.rx_data};
                    end
                end
                S_CHECK: begin
                    // Runts are discarded without touching any statistic.
                    if (r_idx >= MIN_FRAME) begin
                        if (w_crc == CRC32_RESIDUE) begin
                            if (r_good_cnt != 16'hFFFF) r_good_cnt <= r_good_cnt + 16'd1;
                            if (w_arp_match) begin
                                r_reply_valid <= 1'b1;
                                r_reply_mac   <= r_hdr.sha;
                                r_reply_ip    <= r_hdr.spa;
                            end
                        end else begin
                            if (r_crc_err_cnt != 16'hFFFF) r_crc_err_cnt <= r_crc_err_cnt + 16'd1;
                        end
                    end
                    r_state <= S_IDLE;
                end
                S_DROP: begin
                    if (!bus.rx_dv) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.reply_valid = r_reply_valid;
    assign bus.reply_mac   = r_reply_mac;
    assign bus.reply_ip    = r_reply_ip;
    assign bus.good_cnt    = r_good_cnt;
    assign bus.crc_err_cnt = r_crc_err_cnt;
endmodule

// File: tb/tb_arp_reply_rx.sv
// Bench for arp_reply_rx: table of ARP frames plus hand-written runt/oversize/long-preamble/reset cases.
// Latency: expects results on the 2nd edge after rx_dv falls.
// Backpressure: none; bytes are driven back to back.
module tb_arp_reply_rx;
    localparam logic [47:0] LOCAL_MAC = 48'h00301ba0a48e;
    localparam logic [31:0] LOCAL_IP  = 32'h0a00150a;
    localparam logic [31:0] PEER_IP   = 32'h0a001563;
    localparam logic [47:0] BCAST     = 48'hffffffffffff;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    arp_reply_rx_if u_if();

    arp_reply_rx #(.LOCAL_MAC(LOCAL_MAC), .LOCAL_IP(LOCAL_IP), .PEER_IP(PEER_IP)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (u_if)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] fr [0:2047];
    int flen;

    typedef struct packed { logic [47:0] mac; logic [31:0] ip; } exp_t;
    exp_t sb_q[$];

    logic [15:0] exp_good, exp_err;
    logic [47:0] last_mac;
    logic [31:0] last_ip;

    typedef struct {
        logic [47:0] dst;
        logic [15:0] etype;
        logic [15:0] oper;
        logic [47:0] sha;
        logic [31:0] spa;
        logic [31:0] tpa;
        int          pre;
        logic [7:0]  fcs_x;
        logic        exp_reply;
        logic        exp_good;
        logic        exp_err;
    } vec_t;
    vec_t vecs [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int k = 0; k < 8; k++) begin
            r = ((r[0] ^ b[k]) ? 32'hEDB88320 : 32'h0) ^ (r >> 1);
        end
        return r;
    endfunction

    task automatic put_be(input int off, input int n, input logic [63:0] v);
        for (int k = 0; k < n; k++) fr[off + k] = v[8*(n-1-k) +: 8];
    endtask

    task automatic add_fcs(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int k = 0; k < n; k++) c = crc_upd(c, fr[k]);
        c = ~c;
        fr[n]   = c[7:0];
        fr[n+1] = c[15:8];
        fr[n+2] = c[23:16];
        fr[n+3] = c[31:24];
        flen = n + 4;
    endtask

    task automatic build_arp(input logic [47:0] dst, input logic [15:0] etype, input logic [15:0] oper,
                             input logic [47:0] sha, input logic [31:0] spa, input logic [31:0] tpa);
        for (int k = 0; k < 60; k++) fr[k] = 8'h00;
        put_be(0, 6, dst);
        put_be(6, 6, 48'h020000000001);
        put_be(12, 2, etype);
        put_be(14, 2, 16'h0001);
        put_be(16, 2, 16'h0800);
        fr[18] = 8'd6;
        fr[19] = 8'd4;
        put_be(20, 2, oper);
        put_be(22, 6, sha);
        put_be(28, 4, spa);
        put_be(32, 6, LOCAL_MAC);
        put_be(38, 4, tpa);
        add_fcs(60);
    endtask

    task automatic drive(input logic dv, input logic [7:0] d);
        @(negedge clock);
        u_if.rx_dv   = dv;
        u_if.rx_data = d;
    endtask

    task automatic send(input int pre, input logic [7:0] x);
        for (int k = 0; k < pre; k++) drive(1'b1, 8'h55);
        drive(1'b1, 8'hD5);
        for (int k = 0; k < flen; k++) drive(1'b1, (k == flen - 1) ? (fr[k] ^ x) : fr[k]);
        drive(1'b0, 8'h00);
    endtask

    // E0 samples rx_dv=0, results visible after E1, pulse gone after the next edge.
    task automatic check_end(input string name, input logic exp_rv);
        @(posedge clock);
        @(posedge clock);
        #1;
        chk({name, "/reply_valid"}, u_if.reply_valid, exp_rv);
        chk({name, "/good_cnt"},    u_if.good_cnt,    exp_good);
        chk({name, "/crc_err_cnt"}, u_if.crc_err_cnt, exp_err);
        chk({name, "/reply_mac"},   u_if.reply_mac,   last_mac);
        chk({name, "/reply_ip"},    u_if.reply_ip,    last_ip);
        @(posedge clock);
        #1;
        chk({name, "/pulse_end"},   u_if.reply_valid, 1'b0);
    endtask

    task automatic expect_reply(input logic [47:0] sha, input logic [31:0] spa);
        exp_t e;
        e.mac = sha;
        e.ip  = spa;
        sb_q.push_back(e);
        last_mac = sha;
        last_ip  = spa;
    endtask

    // Scoreboard: every reply pulse must match the oldest pending expectation.
    always @(negedge clock) begin
        if (u_if.reply_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("sb/unexpected_reply", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb/mac", u_if.reply_mac, e.mac);
                chk("sb/ip",  u_if.reply_ip,  e.ip);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{LOCAL_MAC, 16'h0806, 16'h0002, 48'h001122334455, PEER_IP, LOCAL_IP,     7, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{LOCAL_MAC, 16'h0806, 16'h0002, 48'h001122334455, PEER_IP, LOCAL_IP,     7, 8'h01, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{BCAST,     16'h0806, 16'h0001, LOCAL_MAC,        LOCAL_IP, PEER_IP,     7, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{LOCAL_MAC, 16'h0806, 16'h0002, 48'h001122334455, PEER_IP, 32'h0a00150b, 7, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{LOCAL_MAC, 16'h0806, 16'h0002, 48'h0a0b0c0d0e0f, PEER_IP, LOCAL_IP,     2, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{BCAST,     16'h0806, 16'h0002, 48'h665544332211, PEER_IP, LOCAL_IP,     0, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{48'h00301ba0a48f, 16'h0806, 16'h0002, 48'h777777777777, PEER_IP, LOCAL_IP, 7, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{LOCAL_MAC, 16'h0800, 16'h0002, 48'h888888888888, PEER_IP, LOCAL_IP,     7, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{LOCAL_MAC, 16'h0806, 16'h0002, 48'h999999999999, 32'h0a001564, LOCAL_IP, 7, 8'h00, 1'b0, 1'b1, 1'b0};

        u_if.rx_dv   = 1'b0;
        u_if.rx_data = 8'h00;
        exp_good = 16'd0;
        exp_err  = 16'd0;
        last_mac = 48'd0;
        last_ip  = 32'd0;

        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset/reply_valid", u_if.reply_valid, 1'b0);
        chk("reset/reply_mac",   u_if.reply_mac,   48'd0);
        chk("reset/reply_ip",    u_if.reply_ip,    32'd0);
        chk("reset/good_cnt",    u_if.good_cnt,    16'd0);
        chk("reset/crc_err_cnt", u_if.crc_err_cnt, 16'd0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            build_arp(vecs[i].dst, vecs[i].etype, vecs[i].oper, vecs[i].sha, vecs[i].spa, vecs[i].tpa);
            if (vecs[i].exp_reply) expect_reply(vecs[i].sha, vecs[i].spa);
            if (vecs[i].exp_good) exp_good = exp_good + 16'd1;
            if (vecs[i].exp_err)  exp_err  = exp_err + 16'd1;
            send(vecs[i].pre, vecs[i].fcs_x);
            check_end($sformatf("vec%0d", i), vecs[i].exp_reply);
        end

        // 40-byte runt with a correct FCS: discarded without counting.
        for (int k = 0; k < 36; k++) fr[k] = 8'($urandom_range(0, 255));
        add_fcs(36);
        send(7, 8'h00);
        check_end("runt40", 1'b0);

        // 1600-byte burst: cut off at the maximum length, no statistics.
        for (int k = 0; k < 1600; k++) fr[k] = 8'($urandom_range(0, 255));
        flen = 1600;
        send(7, 8'h00);
        check_end("burst1600", 1'b0);

        // Eight preamble bytes: otherwise valid reply is dropped.
        build_arp(LOCAL_MAC, 16'h0806, 16'h0002, 48'h123456789abc, PEER_IP, LOCAL_IP);
        send(8, 8'h00);
        check_end("pre8", 1'b0);

        build_arp(LOCAL_MAC, 16'h0806, 16'h0002, 48'ha1a2a3a4a5a6, PEER_IP, LOCAL_IP);
        expect_reply(48'ha1a2a3a4a5a6, PEER_IP);
        exp_good = exp_good + 16'd1;
        send(7, 8'h00);
        check_end("after_drops", 1'b1);

        // Reset pulse while byte 20 of a good reply is on the wire.
        build_arp(LOCAL_MAC, 16'h0806, 16'h0002, 48'hdeadbeef0001, PEER_IP, LOCAL_IP);
        for (int k = 0; k < 7; k++) drive(1'b1, 8'h55);
        drive(1'b1, 8'hD5);
        for (int k = 0; k < flen; k++) begin
            @(negedge clock);
            u_if.rx_dv   = 1'b1;
            u_if.rx_data = fr[k];
            reset_n      = (k != 20);
        end
        drive(1'b0, 8'h00);
        exp_good = 16'd0;
        exp_err  = 16'd0;
        last_mac = 48'd0;
        last_ip  = 32'd0;
        check_end("reset_mid", 1'b0);

        build_arp(BCAST, 16'h0806, 16'h0002, 48'h0c0d0e0f1011, PEER_IP, LOCAL_IP);
        expect_reply(48'h0c0d0e0f1011, PEER_IP);
        exp_good = exp_good + 16'd1;
        send(7, 8'h00);
        check_end("after_reset", 1'b1);

        repeat (2) @(posedge clock);
        chk("sb/pending", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/arp_reply_rx.md
# arp_reply_rx

Receive-side GMII stage paired with the ARP request sender on PHY#1. It consumes the byte stream returned by the PHY (rx_dv/rx_data), strips preamble/SFD, checks the Ethernet FCS, and parses ARP replies addressed to this station. It reports the resolved MAC/IP of the target host plus frame and error statistics; downstream logic uses `reply_valid` to stop retransmitting requests.

## Interface
- LOCAL_MAC, 48'h00301ba0a48e, station MAC; accepted destination besides broadcast.
- LOCAL_IP, 32'h0a00150a (10.0.21.10), required ARP target protocol address (tpa).
- PEER_IP, 32'h0a001563 (10.0.21.99), required ARP sender protocol address (spa).
- clock  in  1  RX byte clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- rx_dv  in  1  GMII receive data valid.
- rx_data  in  8  GMII receive byte.
- reply_valid  out  1  one-cycle pulse: accepted ARP reply.
- reply_mac  out  48  sender hardware address (sha) of last accepted reply.
- reply_ip  out  32  sender protocol address (spa) of last accepted reply.
- good_cnt  out  16  frames with valid FCS, saturating.
- crc_err_cnt  out  16  frames with bad FCS, saturating.

## Operation
- States: IDLE, PRE, BODY, CHECK, DROP. Reset: IDLE; all outputs 0.
- IDLE: rx_dv=1 and rx_data=0x55 -> PRE; rx_dv=1 and 0xD5 -> BODY (zero-length preamble allowed); rx_dv=1 other byte -> DROP.
- PRE: 0x55 stays (max 7 total, 8th 0x55 -> DROP); 0xD5 -> BODY; other byte or rx_dv=0 -> DROP/IDLE respectively.
- BODY: byte index idx starts at 0 on the byte after SFD; each byte feeds CRC and field capture; rx_dv=0 -> CHECK.
- Field offsets: dst 0-5, ethertype 12-13, htype 14-15, ptype 16-17, hlen 18, plen 19, oper 20-21, sha 22-27, spa 28-31, tha 32-37, tpa 38-41. Multi-byte fields big-endian, first byte is MSB.
- idx reaching 1518 with rx_dv still high -> DROP (no counters touched).
- DROP: wait for rx_dv=0, then IDLE. Frame silently discarded.
- CHECK (exactly one cycle, rx_dv ignored): length = idx count incl. FCS.
  - len < 64: discard, no counters.
  - CRC residue wrong: crc_err_cnt++ (saturate at 0xFFFF).
  - CRC good: good_cnt++ (saturate); if dst ∈ {LOCAL_MAC, all-ones}, ethertype 0x0806, htype 0x0001, ptype 0x0800, hlen 6, plen 4, oper 0x0002, spa=PEER_IP, tpa=LOCAL_IP -> reply_valid=1, reply_mac<=sha, reply_ip<=spa.
  - then IDLE; if rx_dv is high there, the IDLE rules apply (a non-preamble byte -> DROP).
- CRC: reflected CRC-32 (poly 0xEDB88320, init 0xFFFFFFFF, LSB-first per byte) over bytes idx 0..end incl. FCS; good iff register = 0xDEBB20E3 (normal form 0xC704DD7B). Capture is FCS-agnostic; decision only in CHECK.
- reply_mac/reply_ip hold last accepted values; change only with reply_valid.
- Reset mid-frame: return to IDLE next edge, counters/outputs cleared; remainder of that frame ignored via DROP-on-non-preamble.

## Timing
- Edge E0 samples rx_dv=0 after BODY -> state CHECK. At E1 reply_valid/reply_mac/reply_ip/counters update; reply_valid high for the single cycle E1-E2.
- No backpressure; one byte per clock while rx_dv=1.
- CRC register updated same edge the byte is sampled; CRC combinational depth one byte step.

## Structure
- Shared package `eth_pkg`: ETHERTYPE_ARP, ETHERTYPE_IPV4, ARP_OPER_REQ/REPLY, PREAMBLE 0x55, SFD 0xD5, CRC32_POLY_REFL, CRC32_RESIDUE, MIN_FRAME 64, MAX_FRAME 1518, field-offset constants.
- Sub-module `crc32_d8`: byte-wide reflected CRC-32 step (init, enable, data in, 32-bit state out); reusable by the TX side.

## Test plan
- 7x0x55+0xD5, ARP reply dst 00-30-1b-a0-a4-8e, sha 00-11-22-33-44-55, spa 10.0.21.99, tpa 10.0.21.10, 18 pad, correct FCS -> reply_valid one cycle at E1, reply_mac=48'h001122334455, reply_ip=32'h0a001563, good_cnt=1.
- Same frame, FCS last byte XOR 0x01 -> no reply_valid, crc_err_cnt=1, reply_mac unchanged.
- The broadcast ARP request (oper=1, spa 10.0.21.10, tpa 10.0.21.99) looped back -> good_cnt+1, no reply_valid.
- Valid reply with tpa 10.0.21.11; then valid reply with 2-byte preamble -> first ignored, second accepted.
- Runt 40-byte frame, then 1600-byte rx_dv burst, then 8x0x55 preamble -> no counter change, FSM back in IDLE after each; following good reply accepted.
- Assert reset_n=0 for one cycle at idx 20 of a good reply -> outputs/counters 0, no reply_valid for that frame; next good reply accepted with good_cnt=1.
